// File: rtl/cache_2way.sv
// cache_2way: 2-way set-associative write-through, no-write-allocate cache with LRU and hit/miss counters
module cache_2way #(
  parameter int addr_size  = 16,
  parameter int index_size = 5,
  parameter int data_size  = 32,
  parameter int cnt_size   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  stall,
  input  logic [addr_size-1:0]  cache_addr,
  input  logic                  en_R,
  input  logic                  en_W,
  input  logic [data_size-1:0]  cache_in,
  output logic [data_size-1:0]  cache_out,
  output logic [addr_size-1:0]  mem_addr,
  output logic                  mem_en_R,
  output logic                  mem_en_W,
  output logic [data_size-1:0]  mem_in,
  input  logic [data_size-1:0]  mem_out,
  input  logic                  mem_ready,
  output logic [cnt_size-1:0]   hit_count,
  output logic [cnt_size-1:0]   miss_count
);
  localparam int tag_size = addr_size - index_size;
  localparam int sets = 2 ** index_size;
  typedef enum logic [1:0] {IDLE, READ_MEM, WRITE_MEM} state_t;
  state_t state, state_n;
  logic [sets-1:0] valid0, valid1, lru;
  logic [tag_size-1:0] tag0 [sets];
  logic [tag_size-1:0] tag1 [sets];
  logic [data_size-1:0] data0 [sets];
  logic [data_size-1:0] data1 [sets];
  logic [index_size-1:0] idx;
  logic [tag_size-1:0] tag;
  logic hit0, hit1, hit, victim, rd_hit, rd_miss, fill, wr_hit;
  assign idx = cache_addr[index_size-1:0];
  assign tag = cache_addr[addr_size-1:index_size];
  assign hit0 = valid0[idx] && tag0[idx] == tag;
  assign hit1 = valid1[idx] && tag1[idx] == tag;
  assign hit = hit0 || hit1;
  assign victim = !valid0[idx] ? 1'b0 : !valid1[idx] ? 1'b1 : lru[idx];
  assign rd_hit = state == IDLE && en_R && !en_W && hit;
  assign rd_miss = state == IDLE && en_R && !en_W && !hit;
  assign fill = state == READ_MEM && mem_ready;
  // write hits update the line when memory acknowledges, so a reset mid-write leaves it untouched
  assign wr_hit = state == WRITE_MEM && mem_ready && hit;
  assign mem_addr = cache_addr;
  assign mem_in = cache_in;
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
  end
  always_comb begin
    state_n = state == IDLE ? (en_W ? WRITE_MEM : rd_miss ? READ_MEM : IDLE) : mem_ready ? IDLE : state;
  end
  always_comb begin
    stall = state == IDLE ? (en_W || (en_R && !hit)) : !mem_ready;
    cache_out = state == READ_MEM ? mem_out : hit1 ? data1[idx] : data0[idx];
    mem_en_R = state == READ_MEM;
    mem_en_W = state == WRITE_MEM;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid0 <= '0;
      valid1 <= '0;
      lru <= '0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (fill) begin
        if (victim) begin
          valid1[idx] <= 1'b1;
          tag1[idx] <= tag;
          data1[idx] <= mem_out;
        end else begin
          valid0[idx] <= 1'b1;
          tag0[idx] <= tag;
          data0[idx] <= mem_out;
        end
        lru[idx] <= !victim;
      end
      if (wr_hit) begin
        if (hit1) data1[idx] <= cache_in;
        else data0[idx] <= cache_in;
        lru[idx] <= hit0;
      end
      if (rd_hit) lru[idx] <= hit0;
      if (rd_hit && hit_count != '1) hit_count <= hit_count + cnt_size'(1);
      if (rd_miss && miss_count != '1) miss_count <= miss_count + cnt_size'(1);
    end
  end
endmodule
